// File: rtl/pipe_stage_skid.sv
// Two-entry pipeline register with a skid slot: it breaks the ready path between stages
// and keeps full throughput.
//
//   state | meaning
//   ------+------------------------------------------
//   EMPTY | no entry held, output is a bubble
//   ONE   | head (main) register valid
//   TWO   | head and skid registers valid, stalls upstream
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e            state_q;
  logic [DATA_W-1:0] main_data_q;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [DATA_W-1:0] skid_data_q;
  logic [CTRL_W-1:0] skid_ctrl_q;

  logic in_fire;
  logic out_fire;

  // Handshake status comes straight from the state flops, so out_ready never
  // reaches in_ready combinationally.
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  assign out_data  = main_data_q;
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;

  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      ONE:     occupancy = 2'd1;
      TWO:     occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else if (flush) begin
      // Payload registers are left alone so out_data keeps its last value.
      state_q <= EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_data_q <= in_data;
            main_ctrl_q <= in_ctrl;
            state_q     <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_data_q <= in_data;
            main_ctrl_q <= in_ctrl;
          end else if (in_fire) begin
            skid_data_q <= in_data;
            skid_ctrl_q <= in_ctrl;
            state_q     <= TWO;
          end else if (out_fire) begin
            state_q <= EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            main_data_q <= skid_data_q;
            main_ctrl_q <= skid_ctrl_q;
            state_q     <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomized and directed bench for pipe_stage_skid: the stimulus side keeps a queue
// model of accepted entries, and a monitor pops it on every output handshake.
module tb_pipe_stage_skid;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: entries accepted but not yet consumed, oldest first
  logic [CW+DW-1:0] exp_q[$];
  int               cnt = 0;
  logic             ifire = 1'b0;
  logic             ofire = 1'b0;
  logic             fl_cur = 1'b0;
  logic [CW+DW-1:0] ent_cur = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: commit the previous cycle's handshakes to the model, then drive new inputs
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                     input logic r, input logic f);
    @(posedge clk);
    if (fl_cur) begin
      exp_q.delete();
      cnt = 0;
    end else begin
      if (ofire) cnt--;
      if (ifire) begin
        exp_q.push_back(ent_cur);
        cnt++;
      end
    end
    #1;
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = r;
    flush     = f;
    ifire   = v && (cnt < 2);
    ofire   = (cnt > 0) && r;
    fl_cur  = f;
    ent_cur = {c, d};
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    exp_q.delete();
    cnt = 0; ifire = 1'b0; ofire = 1'b0; fl_cur = 1'b0;
    in_valid = 1'b0; flush = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_ctrl",  64'(out_ctrl),  64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: status against model occupancy every cycle, payload on each out handshake
  initial begin
    forever begin
      @(negedge clk);
      chk("out_valid", 64'(out_valid), 64'(cnt != 0));
      chk("in_ready",  64'(in_ready),  64'(cnt != 2));
      chk("occupancy", 64'(occupancy), 64'(cnt));
      if (cnt == 0) chk("bubble_ctrl", 64'(out_ctrl), 64'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got data 0x%0h ctrl 0x%0h with no entry expected",
                   out_data, out_ctrl);
        end else begin
          logic [CW+DW-1:0] e;
          e = exp_q.pop_front();
          chk("out_data", 64'(out_data), 64'(e[DW-1:0]));
          chk("out_ctrl", 64'(out_ctrl), 64'(e[CW+DW-1:DW]));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
    #3;
    chk("init_out_valid", 64'(out_valid), 64'd0);
    chk("init_in_ready",  64'(in_ready),  64'd1);
    chk("init_out_data",  64'(out_data),  64'd0);
    chk("init_occupancy", 64'(occupancy), 64'd0);
    #4 rst_n = 1'b1;

    // Pass-through
    cyc(1, 32'h11, 4'h5, 1, 0);
    cyc(1, 32'h22, 4'h5, 1, 0);
    cyc(1, 32'h33, 4'h5, 1, 0);
    cyc(0, 32'h0,  4'h0, 1, 0);
    cyc(0, 32'h0,  4'h0, 1, 0);

    // Backpressure
    cyc(1, 32'hA0, 4'h3, 0, 0);
    cyc(1, 32'hB0, 4'h6, 0, 0);
    cyc(0, 32'h0,  4'h0, 0, 0);
    cyc(1, 32'hC0, 4'h1, 0, 0);
    cyc(0, 32'h0,  4'h0, 1, 0);
    cyc(0, 32'h0,  4'h0, 1, 0);
    cyc(0, 32'h0,  4'h0, 1, 0);

    // Simultaneous accept and consume in ONE
    cyc(1, 32'h01, 4'h2, 0, 0);
    cyc(1, 32'h02, 4'h4, 1, 0);
    cyc(0, 32'h0,  4'h0, 0, 0);
    cyc(0, 32'h0,  4'h0, 1, 0);

    // Flush from TWO with a same-cycle input that must be discarded
    cyc(1, 32'h10, 4'h1, 0, 0);
    cyc(1, 32'h20, 4'h2, 0, 0);
    cyc(1, 32'hFF, 4'hF, 0, 1);
    cyc(0, 32'h0,  4'h0, 1, 0);
    cyc(0, 32'h0,  4'h0, 1, 0);

    // Reset while TWO, then a fresh entry
    cyc(1, 32'h30, 4'h3, 0, 0);
    cyc(1, 32'h40, 4'h4, 0, 0);
    cyc(0, 32'h0,  4'h0, 0, 0);
    reset_pulse();
    cyc(1, 32'h7,  4'h7, 1, 0);
    cyc(0, 32'h0,  4'h0, 1, 0);
    cyc(0, 32'h0,  4'h0, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 3) != 0), $urandom, 4'($urandom), ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 40) == 0));
    end

    for (int i = 0; i < 4; i++) cyc(0, 32'h0, 4'h0, 1, 0);
    @(negedge clk);
    chk("drained_queue", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, width of the datapath payload (ALU result, store data, PC+4 packed by the instantiating stage).
REQ-002 The block SHALL have parameter CTRL_W, default 4, width of the control payload (RegWrite, MemWrite, ResultSrc, ...).
REQ-003 The block SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port flush  input  1  synchronous kill of all held entries.
REQ-006 The block SHALL have port in_valid  input  1  upstream entry present.
REQ-007 The block SHALL have port in_ready  output  1  block can accept this cycle.
REQ-008 The block SHALL have port in_ctrl  input  CTRL_W  upstream control bits.
REQ-009 The block SHALL have port in_data  input  DATA_W  upstream payload.
REQ-010 The block SHALL have port out_valid  output  1  downstream entry present.
REQ-011 The block SHALL have port out_ready  input  1  downstream consumes this cycle.
REQ-012 The block SHALL have port out_ctrl  output  CTRL_W  control bits of head entry.
REQ-013 The block SHALL have port out_data  output  DATA_W  payload of head entry.
REQ-014 The block SHALL have port occupancy  output  2  entries held (0..2).

Function
REQ-015 The block SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-016 The block SHALL hold a main register (head) and one skid register; state SHALL be one of EMPTY (0 entries), ONE (main valid), TWO (main+skid valid).
REQ-017 The block SHALL drive in_ready = (state != TWO), decoded from flops only; no combinational path from out_ready to in_ready.
REQ-018 The block SHALL drive out_valid = (state != EMPTY), out_data/out_ctrl from the main register; occupancy = 0/1/2 for EMPTY/ONE/TWO.
REQ-019 The block SHALL force out_ctrl to all-zero whenever out_valid = 0 (bubble); out_data SHALL hold its last value when out_valid = 0.
REQ-020 EMPTY: in_fire -> main<=in, ONE; otherwise stay.
REQ-021 ONE: in_fire & out_fire -> main<=in, stay ONE; in_fire & !out_ready -> skid<=in, TWO; !in_fire & out_fire -> EMPTY; else hold.
REQ-022 TWO: out_fire -> main<=skid, ONE; otherwise hold; in_valid ignored (in_ready=0).
REQ-023 Latency SHALL be one cycle: entry accepted at edge N appears with out_valid=1 after edge N when the block was EMPTY or ONE-with-out_fire.
REQ-024 With out_ready held 1, the block SHALL sustain one entry per cycle with no bubbles.
REQ-025 Entries SHALL leave in acceptance order, never dropped, never duplicated (except by flush).
REQ-026 While out_valid=1 and out_ready=0, out_data/out_ctrl SHALL stay stable.
REQ-027 flush=1 SHALL have highest priority: next state EMPTY, any same-cycle in_fire discarded, out_ctrl zero after the edge.
REQ-028 The block SHALL NOT require in_valid to be held; upstream holding is its own obligation when in_ready=0.

Reset
REQ-029 rst_n=0 SHALL asynchronously force state EMPTY and clear main and skid registers to zero; out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1 during and after reset.
REQ-030 Reset deassertion SHALL be taken synchronously to clk; first accept possible on the first rising edge with rst_n=1.
REQ-031 Reset asserted mid-operation SHALL discard both entries without any out_fire.

Verification
REQ-032 Pass-through: out_ready=1, send data 0x11,0x22,0x33 ctrl 0x5 on consecutive cycles -> same order out, one cycle later, occupancy 1 throughout, in_ready=1.
REQ-033 Backpressure: out_ready=0, send 0xA0 then 0xB0 -> occupancy 2, in_ready=0, out_data=0xA0 stable; raise out_ready -> 0xA0 then 0xB0 out, in_ready back to 1.
REQ-034 Simultaneous: state ONE holding 0x01, in_fire 0x02 with out_fire same cycle -> next cycle out_data=0x02, occupancy 1.
REQ-035 Flush: state TWO, flush=1 with in_valid=1 (0xFF, ctrl 0xF) -> next cycle occupancy 0, out_valid=0, out_ctrl=0x0, 0xFF never appears.
REQ-036 Reset mid-stream: state TWO, pulse rst_n=0 between edges -> outputs zero immediately, in_ready=1; after release, new entry 0x7 passes normally.
